power_manager: RTL and testbench
================================

Name: power_manager

Overview:
- Control-side counterpart of the Power level tracker: consumes its level and warning outputs and drives its powerSetting/powerMode inputs.
- A registered FSM arbitrates user load requests and charge requests against the battery level.
- Applies warn-debounced throttling, a hard lockout with forced recharge at depletion, and charge-until-full/resume thresholds.
- Sits between the user/control inputs and the Power block in the ALU system top level.

Parameters:
- FULL_LEVEL, 179, level at or above which CHARGE ends (matches tracker ceiling).
- RESUME_LEVEL, 90, level LOCKOUT must recharge to before release.
- WARN_DWELL, 4, consecutive powerWarn cycles in RUN before THROTTLE (1..15).
- CHARGE_RATE, 3, powerSetting driven during CHARGE (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  manager enable; 0 freezes all state and outputs.
- userSetting  in  2  requested load: 0 off, 1 low, 2 moderate, 3 high.
- chargeReq  in  1  level-sensitive request to recharge.
- powerLevel  in  8  current level from tracker (seconds).
- powerWarn  in  1  low-level flag from tracker.
- powerSetting  out  2  to tracker: use/recharge amount.
- powerMode  out  1  to tracker: 0 recharge, 1 use.
- shutdown  out  1  high while locked out; load must be disconnected.
- stateOut  out  3  current state code.

Behaviour:
- All outputs are registered. Outputs reflect the current state (Moore), so they change one cycle after the deciding edge.
- Reset (rst=0, async): state OFF, powerSetting=0, powerMode=0, shutdown=0, stateOut=0, warn counter=0.
- en=0: state, counter and outputs hold. Inputs are ignored until en=1.
- State codes: OFF=0, RUN=1, THROTTLE=2, CHARGE=3, LOCKOUT=4. Codes 5-7 are illegal and return to OFF on the next edge.
- Outputs per state (setting/mode/shutdown):
  - OFF: 0/0/0.
  - RUN: userSetting (sampled each cycle)/1/0.
  - THROTTLE: 1/1/0.
  - CHARGE: CHARGE_RATE/0/0.
  - LOCKOUT: 1/0/1.
- OFF transitions, in priority order:
  - chargeReq → CHARGE.
  - userSetting!=0 and powerLevel>=userSetting and powerLevel!=0 → RUN.
  - Otherwise stay.
- RUN transitions, in priority order:
  - powerLevel==0 or powerLevel<userSetting → LOCKOUT.
  - chargeReq → CHARGE.
  - userSetting==0 → OFF.
  - warn counter reaches WARN_DWELL → THROTTLE.
- THROTTLE transitions, in priority order:
  - powerLevel==0 → LOCKOUT.
  - chargeReq → CHARGE.
  - userSetting==0 → OFF.
  - Otherwise stay. There is no return to RUN without recharge.
- CHARGE transitions, in priority order:
  - powerLevel>=FULL_LEVEL → OFF.
  - chargeReq==0 → RUN if userSetting!=0 and powerLevel>=userSetting, else OFF.
- LOCKOUT transitions:
  - powerLevel>=RESUME_LEVEL → OFF.
  - chargeReq and userSetting are ignored.
- Warn counter (4-bit):
  - In RUN with powerWarn=1: increments, saturating at WARN_DWELL.
  - Clears when powerWarn=0 or state!=RUN.
  - With WARN_DWELL=4, the 4th consecutive warn edge in RUN moves the FSM to THROTTLE.
- Simultaneous events: priority order above is binding, e.g. depletion beats chargeReq, chargeReq beats userSetting=0.
- Reset asserted mid-CHARGE or mid-LOCKOUT: immediate return to OFF with outputs 0 and shutdown cleared asynchronously.
- Comparisons are unsigned 8-bit; userSetting is zero-extended.

Test Plan:
- Reset, then userSetting=2, powerLevel=100, powerWarn=0 → stateOut=1, powerSetting=2, powerMode=1 one cycle after the deciding edge.
- RUN userSetting=3, powerWarn=1 for 3 cycles then 0, then 1 for 4 cycles → no THROTTLE after the first burst; stateOut=2, powerSetting=1 after the 4th edge of the second burst.
- THROTTLE, powerLevel driven to 0 → stateOut=4, shutdown=1, powerMode=0, powerSetting=1. Raise level to 89 → stays 4; level 90 → stateOut=0, shutdown=0.
- OFF, chargeReq=1, level 50 → CHARGE with powerSetting=3, powerMode=0; level 179 → OFF even with chargeReq still 1, then re-enters CHARGE next cycle.
- RUN, chargeReq=1 and userSetting=0 on the same edge → CHARGE. Separately, RUN with level=1, userSetting=3 and chargeReq=1 → LOCKOUT.
- Mid-CHARGE: en=0 for 5 cycles → outputs and state frozen. Then pulse rst low between clock edges → outputs 0 immediately, stateOut=0.

Source files
------------

// File: rtl/power_manager.sv
// power_manager: control FSM that arbitrates user load and charge requests
// against the battery level reported by the power level tracker, and drives
// the tracker's powerSetting/powerMode inputs.
module power_manager #(
    parameter int unsigned FULL_LEVEL   = 179,
    parameter int unsigned RESUME_LEVEL = 90,
    parameter int unsigned WARN_DWELL   = 4,
    parameter int unsigned CHARGE_RATE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] userSetting,
    input  logic       chargeReq,
    input  logic [7:0] powerLevel,
    input  logic       powerWarn,
    output logic [1:0] powerSetting,
    output logic       powerMode,
    output logic       shutdown,
    output logic [2:0] stateOut
);

    localparam int unsigned LVL_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SET_W = 2;
    localparam int unsigned ST_W  = 3;

    typedef enum logic [ST_W-1:0] {
        ST_OFF      = 3'd0,
        ST_RUN      = 3'd1,
        ST_THROTTLE = 3'd2,
        ST_CHARGE   = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [SET_W-1:0]   set_d;
    logic               mode_d;
    logic               shut_d;
    logic [LVL_W-1:0]   us_ext;
    logic               depleted;
    logic               can_run;
    logic               full;
    logic               resumed;

    // Level comparisons shared by the transition logic (unsigned, zero-extended request)
    always_comb begin
        us_ext   = LVL_W'(userSetting);
        depleted = (powerLevel == '0) || (powerLevel < us_ext);
        can_run  = (userSetting != '0) && (powerLevel >= us_ext) && (powerLevel != '0);
        full     = (powerLevel >= LVL_W'(FULL_LEVEL));
        resumed  = (powerLevel >= LVL_W'(RESUME_LEVEL));
    end

    // Next state, warn dwell counter and the Moore outputs of the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        set_d   = '0;
        mode_d  = 1'b0;
        shut_d  = 1'b0;

        // Consecutive warn cycles only count while running, saturating at the dwell
        if (state_q == ST_RUN && powerWarn) begin
            cnt_d = (cnt_q >= CNT_W'(WARN_DWELL)) ? CNT_W'(WARN_DWELL) : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_OFF: begin
                if (chargeReq)    state_d = ST_CHARGE;
                else if (can_run) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (depleted)                          state_d = ST_LOCKOUT;
                else if (chargeReq)                    state_d = ST_CHARGE;
                else if (userSetting == '0)            state_d = ST_OFF;
                else if (cnt_d == CNT_W'(WARN_DWELL))  state_d = ST_THROTTLE;
            end
            ST_THROTTLE: begin
                // No way back to RUN without a recharge
                if (powerLevel == '0)       state_d = ST_LOCKOUT;
                else if (chargeReq)         state_d = ST_CHARGE;
                else if (userSetting == '0) state_d = ST_OFF;
            end
            ST_CHARGE: begin
                if (full)            state_d = ST_OFF;
                else if (!chargeReq) state_d = can_run ? ST_RUN : ST_OFF;
            end
            ST_LOCKOUT: begin
                if (resumed) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        case (state_d)
            ST_RUN: begin
                set_d  = userSetting;
                mode_d = 1'b1;
            end
            ST_THROTTLE: begin
                set_d  = SET_W'(1);
                mode_d = 1'b1;
            end
            ST_CHARGE: begin
                set_d  = SET_W'(CHARGE_RATE);
            end
            ST_LOCKOUT: begin
                set_d  = SET_W'(1);
                shut_d = 1'b1;
            end
            default: begin
                set_d  = '0;
            end
        endcase
    end

    // State, counter and output registers; en=0 freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            powerSetting <= '0;
            powerMode    <= 1'b0;
            shutdown     <= 1'b0;
        end else if (en) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            powerSetting <= set_d;
            powerMode    <= mode_d;
            shutdown     <= shut_d;
        end
    end

    assign stateOut = ST_W'(state_q);

endmodule

// File: tb/tb_power_manager.sv
// Directed testbench for power_manager with hand-computed expectations.
module tb_power_manager;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] userSetting;
    logic       chargeReq;
    logic [7:0] powerLevel;
    logic       powerWarn;
    logic [1:0] powerSetting;
    logic       powerMode;
    logic       shutdown;
    logic [2:0] stateOut;

    int checks = 0;
    int errors = 0;

    power_manager dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .userSetting  (userSetting),
        .chargeReq    (chargeReq),
        .powerLevel   (powerLevel),
        .powerWarn    (powerWarn),
        .powerSetting (powerSetting),
        .powerMode    (powerMode),
        .shutdown     (shutdown),
        .stateOut     (stateOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected state/setting/mode/shutdown
    task automatic chk(input string tag, input logic [2:0] st, input logic [1:0] set,
                       input logic mode, input logic shut);
        checks++;
        assert (stateOut === st) else begin
            errors++;
            $error("FAIL %s stateOut: observed %0d expected %0d", tag, stateOut, st);
        end
        checks++;
        assert (powerSetting === set) else begin
            errors++;
            $error("FAIL %s powerSetting: observed %0d expected %0d", tag, powerSetting, set);
        end
        checks++;
        assert (powerMode === mode) else begin
            errors++;
            $error("FAIL %s powerMode: observed %0d expected %0d", tag, powerMode, mode);
        end
        checks++;
        assert (shutdown === shut) else begin
            errors++;
            $error("FAIL %s shutdown: observed %0d expected %0d", tag, shutdown, shut);
        end
    endtask

    initial begin
        rst         = 1'b0;
        en          = 1'b1;
        userSetting = 2'd0;
        chargeReq   = 1'b0;
        powerLevel  = 8'd0;
        powerWarn   = 1'b0;

        // Reset state
        #12;
        chk("reset", 3'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk("off_idle", 3'd0, 2'd0, 1'b0, 1'b0);

        // OFF -> RUN
        userSetting = 2'd2;
        powerLevel  = 8'd100;
        step();
        chk("off_to_run", 3'd1, 2'd2, 1'b1, 1'b0);

        // Setting follows userSetting in RUN; short warn burst does not throttle
        userSetting = 2'd3;
        step();
        chk("run_us3", 3'd1, 2'd3, 1'b1, 1'b0);
        powerWarn = 1'b1;
        step();
        step();
        step();
        chk("warn_burst3", 3'd1, 2'd3, 1'b1, 1'b0);
        powerWarn = 1'b0;
        step();
        chk("warn_clear", 3'd1, 2'd3, 1'b1, 1'b0);
        powerWarn = 1'b1;
        step();
        step();
        step();
        chk("warn_third", 3'd1, 2'd3, 1'b1, 1'b0);
        step();
        chk("throttle", 3'd2, 2'd1, 1'b1, 1'b0);

        // THROTTLE depletion -> LOCKOUT, release exactly at the resume level
        powerWarn  = 1'b0;
        powerLevel = 8'd0;
        step();
        chk("lockout", 3'd4, 2'd1, 1'b0, 1'b1);
        powerLevel = 8'd89;
        chargeReq  = 1'b1;
        step();
        chk("lockout_89", 3'd4, 2'd1, 1'b0, 1'b1);
        chargeReq  = 1'b0;
        userSetting = 2'd0;
        powerLevel = 8'd90;
        step();
        chk("lockout_90", 3'd0, 2'd0, 1'b0, 1'b0);

        // OFF -> CHARGE, full ends charge even with request held, then re-enters
        chargeReq  = 1'b1;
        powerLevel = 8'd50;
        step();
        chk("charge", 3'd3, 2'd3, 1'b0, 1'b0);
        powerLevel = 8'd178;
        step();
        chk("charge_178", 3'd3, 2'd3, 1'b0, 1'b0);
        powerLevel = 8'd179;
        step();
        chk("charge_full", 3'd0, 2'd0, 1'b0, 1'b0);
        step();
        chk("charge_again", 3'd3, 2'd3, 1'b0, 1'b0);

        // CHARGE released with a valid load -> RUN; chargeReq beats userSetting=0
        chargeReq   = 1'b0;
        powerLevel  = 8'd100;
        userSetting = 2'd2;
        step();
        chk("charge_to_run", 3'd1, 2'd2, 1'b1, 1'b0);
        chargeReq   = 1'b1;
        userSetting = 2'd0;
        step();
        chk("req_beats_off", 3'd3, 2'd3, 1'b0, 1'b0);

        // Depletion beats chargeReq in RUN
        chargeReq   = 1'b0;
        userSetting = 2'd1;
        step();
        chk("run_again", 3'd1, 2'd1, 1'b1, 1'b0);
        powerLevel  = 8'd1;
        userSetting = 2'd3;
        chargeReq   = 1'b1;
        step();
        chk("deplete_beats_req", 3'd4, 2'd1, 1'b0, 1'b1);
        chargeReq   = 1'b0;
        userSetting = 2'd0;
        powerLevel  = 8'd90;
        step();
        chk("release_off", 3'd0, 2'd0, 1'b0, 1'b0);

        // OFF boundary: level just below/at the requested load
        userSetting = 2'd3;
        powerLevel  = 8'd2;
        step();
        chk("off_level_low", 3'd0, 2'd0, 1'b0, 1'b0);
        powerLevel = 8'd3;
        step();
        chk("off_level_eq", 3'd1, 2'd3, 1'b1, 1'b0);
        chargeReq = 1'b1;
        step();
        chk("run_to_charge", 3'd3, 2'd3, 1'b0, 1'b0);

        // en=0 freezes state and outputs regardless of inputs
        en          = 1'b0;
        chargeReq   = 1'b0;
        powerLevel  = 8'd200;
        userSetting = 2'd1;
        step();
        step();
        chk("freeze_2", 3'd3, 2'd3, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("freeze_5", 3'd3, 2'd3, 1'b0, 1'b0);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", 3'd0, 2'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        en  = 1'b1;
        step();
        chk("post_rst_run", 3'd1, 2'd1, 1'b1, 1'b0);

        // Asynchronous reset also clears shutdown from LOCKOUT
        powerLevel = 8'd0;
        step();
        chk("lockout_again", 3'd4, 2'd1, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_lock", 3'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
